// File: rtl/csp_pkg.sv
// Shared encodings for the CSP merge/split pair: FSM states and select-token ids.
// The split consumes the same select encoding to route tokens back.
package csp_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      SEND   = 2'd1,
      ACK_IN = 2'd2
   } state_e;

   localparam logic SEL_IN1 = 1'b0;
   localparam logic SEL_IN2 = 1'b1;

   // One-hot grant to source id; bit 1 of the grant means in2.
   function automatic logic grant_to_sel(input logic [1:0] grant);
      return grant[1] ? SEL_IN2 : SEL_IN1;
   endfunction

endpackage

// File: rtl/csp_merge2_if.sv
// Four-phase channels around csp_merge2: two input channels, merged output, select.
// master = the merge itself (drives out/sel and the input acks), slave = its environment.
interface csp_merge2_if #(
   parameter int WIDTH = 8
) ();

   logic             in1_req;
   logic [WIDTH-1:0] in1_data;
   logic             in1_ack;

   logic             in2_req;
   logic [WIDTH-1:0] in2_data;
   logic             in2_ack;

   logic             out_req;
   logic [WIDTH-1:0] out_data;
   logic             out_ack;

   logic             sel_req;
   logic             sel_data;
   logic             sel_ack;

   modport master (
      input  in1_req, in1_data,
      output in1_ack,
      input  in2_req, in2_data,
      output in2_ack,
      output out_req, out_data,
      input  out_ack,
      output sel_req, sel_data,
      input  sel_ack
   );

   modport slave (
      output in1_req, in1_data,
      input  in1_ack,
      output in2_req, in2_data,
      input  in2_ack,
      input  out_req, out_data,
      output out_ack,
      input  sel_req, sel_data,
      output sel_ack
   );

endinterface

// File: rtl/csp_merge2_rr_arbiter2.sv
// Combinational 2-way round-robin arbiter: on a tie the input not granted last wins.
// req[0] is in1, req[1] is in2; last_grant uses the select encoding.
module rr_arbiter2
   import csp_pkg::*;
(
   input  logic [1:0] req_i,
   input  logic       last_grant_i,
   output logic [1:0] grant_o,
   output logic       valid_o
);

   always_comb begin
      grant_o = 2'b00;
      unique case (req_i)
         2'b01:   grant_o = 2'b01;
         2'b10:   grant_o = 2'b10;
         2'b11:   grant_o = (last_grant_i == SEL_IN2) ? 2'b01 : 2'b10;
         default: grant_o = 2'b00;
      endcase
   end

   assign valid_o = |req_i;

endmodule

// File: rtl/csp_merge2.sv
// Two-way four-phase CSP merge with round-robin arbitration and a companion select token.
// One edge from sampled request to out_req/sel_req; all outputs registered.
module csp_merge2
   import csp_pkg::*;
#(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             reset,
   csp_merge2_if.master     bus
);

   state_e           state_q;
   logic             last_grant_q;
   logic             in1_ack_q;
   logic             in2_ack_q;
   logic             out_req_q;
   logic [WIDTH-1:0] out_data_q;
   logic             sel_req_q;
   logic             sel_data_q;

   logic [1:0]       grant;
   logic             arb_vld;
   logic             winner_req;

   rr_arbiter2 u_arb (
      .req_i        ({bus.in2_req, bus.in1_req}),
      .last_grant_i (last_grant_q),
      .grant_o      (grant),
      .valid_o      (arb_vld)
   );

   // sel_data_q holds the winner id from grant until the next grant.
   assign winner_req = (sel_data_q == SEL_IN2) ? bus.in2_req : bus.in1_req;

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q      <= IDLE;
         last_grant_q <= SEL_IN2;
         in1_ack_q    <= 1'b0;
         in2_ack_q    <= 1'b0;
         out_req_q    <= 1'b0;
         out_data_q   <= '0;
         sel_req_q    <= 1'b0;
         sel_data_q   <= SEL_IN1;
      end else begin
         unique case (state_q)
            IDLE: begin
               if (arb_vld) begin
                  out_data_q <= grant[1] ? bus.in2_data : bus.in1_data;
                  sel_data_q <= grant_to_sel(grant);
                  out_req_q  <= 1'b1;
                  sel_req_q  <= 1'b1;
                  state_q    <= SEND;
               end
            end
            SEND: begin
               if (out_req_q && bus.out_ack) out_req_q <= 1'b0;
               if (sel_req_q && bus.sel_ack) sel_req_q <= 1'b0;
               // Release the source only once both downstream handshakes are fully closed.
               if (!out_req_q && !sel_req_q && !bus.out_ack && !bus.sel_ack) begin
                  if (sel_data_q == SEL_IN2) in2_ack_q <= 1'b1;
                  else                       in1_ack_q <= 1'b1;
                  state_q <= ACK_IN;
               end
            end
            ACK_IN: begin
               if (!winner_req) begin
                  in1_ack_q    <= 1'b0;
                  in2_ack_q    <= 1'b0;
                  last_grant_q <= sel_data_q;
                  state_q      <= IDLE;
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign bus.in1_ack  = in1_ack_q;
   assign bus.in2_ack  = in2_ack_q;
   assign bus.out_req  = out_req_q;
   assign bus.out_data = out_data_q;
   assign bus.sel_req  = sel_req_q;
   assign bus.sel_data = sel_data_q;

endmodule

// File: tb/tb_csp_merge2.sv
// Directed bench for csp_merge2: sources drive tokens, a responder acks out/sel and
// scores each token against a queue of expected {sel,data} pushed with the stimulus.
module tb_csp_merge2;
   import csp_pkg::*;

   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   csp_merge2_if #(.WIDTH(8)) bus ();

   csp_merge2 #(.WIDTH(8)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   int errors = 0;
   int checks = 0;
   logic [9:0] sb[$];
   int out_dly = 0;
   int sel_dly = 0;
   int in1_hi = 0;
   int in2_hi = 0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Responder on out/sel with programmable ack delays plus invariant monitor.
   initial begin
      int out_cnt = 0;
      int sel_cnt = 0;
      logic out_prev = 1'b0;
      logic in1_prev = 1'b0;
      logic in2_prev = 1'b0;
      logic [9:0] exp;
      forever begin
         @(negedge clk);
         if (reset) begin
            bus.out_ack = 1'b0;
            bus.sel_ack = 1'b0;
            out_cnt = 0;
            sel_cnt = 0;
            out_prev = 1'b0;
            in1_prev = 1'b0;
            in2_prev = 1'b0;
         end else begin
            if (bus.in1_ack || bus.in2_ack) begin
               chk("in_ack_exclusive", bus.in1_ack & bus.in2_ack, 0);
               chk("in_ack_vs_out_sel_req", bus.out_req | bus.sel_req, 0);
            end
            if ((bus.in1_ack && !in1_prev) || (bus.in2_ack && !in2_prev))
               chk("in_ack_vs_out_sel_ack", bus.out_ack | bus.sel_ack, 0);
            in1_prev = bus.in1_ack;
            in2_prev = bus.in2_ack;
            in1_hi += int'(bus.in1_ack);
            in2_hi += int'(bus.in2_ack);
            if (bus.out_req && !out_prev) begin
               exp = (sb.size() > 0) ? sb.pop_front() : 10'h3FF;
               chk("token", {1'b0, bus.sel_data, bus.out_data}, exp);
               chk("sel_req_with_out_req", bus.sel_req, 1);
            end
            out_prev = bus.out_req;
            if (bus.out_req && !bus.out_ack) begin
               if (out_cnt >= out_dly) bus.out_ack = 1'b1;
               else out_cnt++;
            end else if (!bus.out_req) begin
               bus.out_ack = 1'b0;
               out_cnt = 0;
            end
            if (bus.sel_req && !bus.sel_ack) begin
               if (sel_cnt >= sel_dly) bus.sel_ack = 1'b1;
               else sel_cnt++;
            end else if (!bus.sel_req) begin
               bus.sel_ack = 1'b0;
               sel_cnt = 0;
            end
         end
      end
   end

   task automatic send_tok(input int ch, input logic [7:0] d);
      bit got = 0;
      if (ch == 1) begin bus.in1_data = d; bus.in1_req = 1'b1; end
      else         begin bus.in2_data = d; bus.in2_req = 1'b1; end
      for (int i = 0; i < 300 && !got; i++) begin
         @(negedge clk);
         got = (ch == 1) ? bus.in1_ack : bus.in2_ack;
      end
      chk("src_ack_rise", got, 1);
      if (ch == 1) bus.in1_req = 1'b0;
      else         bus.in2_req = 1'b0;
      got = 0;
      for (int i = 0; i < 300 && !got; i++) begin
         @(negedge clk);
         got = (ch == 1) ? !bus.in1_ack : !bus.in2_ack;
      end
      chk("src_ack_fall", got, 1);
   endtask

   task automatic drain(input string tag);
      bit done = 0;
      for (int i = 0; i < 500 && !done; i++) begin
         @(negedge clk);
         done = (sb.size() == 0) && !bus.out_req && !bus.sel_req && !bus.in1_ack
                && !bus.in2_ack && !bus.in1_req && !bus.in2_req;
      end
      chk(tag, done, 1);
   endtask

   initial begin
      int h1;
      bus.in1_req = 1'b0; bus.in1_data = '0;
      bus.in2_req = 1'b0; bus.in2_data = '0;
      bus.out_ack = 1'b0; bus.sel_ack = 1'b0;
      reset = 1'b1;
      repeat (3) @(negedge clk);
      chk("rst_out_req", bus.out_req, 0);
      chk("rst_sel_req", bus.sel_req, 0);
      chk("rst_in1_ack", bus.in1_ack, 0);
      chk("rst_in2_ack", bus.in2_ack, 0);
      chk("rst_out_data", bus.out_data, 0);
      chk("rst_sel_data", bus.sel_data, 0);
      chk("rst_state", dut.state_q, IDLE);
      chk("rst_last_grant", dut.last_grant_q, SEL_IN2);
      reset = 1'b0;
      @(negedge clk);

      // Single token on in1 with one-edge latency check.
      sb.push_back({1'b0, SEL_IN1, 8'hA5});
      fork
         send_tok(1, 8'hA5);
         begin
            @(negedge clk);
            chk("t1_out_req_latency", bus.out_req, 1);
            chk("t1_sel_req_latency", bus.sel_req, 1);
            chk("t1_out_data", bus.out_data, 8'hA5);
            chk("t1_sel_data", bus.sel_data, SEL_IN1);
         end
      join
      drain("t1_drain");
      chk("t1_in2_ack_quiet", in2_hi, 0);

      // Single token on in2.
      h1 = in1_hi;
      sb.push_back({1'b0, SEL_IN2, 8'h3C});
      send_tok(2, 8'h3C);
      drain("t2_drain");
      chk("t2_in1_ack_quiet", in1_hi, h1);

      // Simultaneous requests straight out of reset: in1 wins the tie.
      reset = 1'b1;
      repeat (2) @(negedge clk);
      reset = 1'b0;
      sb.push_back({1'b0, SEL_IN1, 8'h11});
      sb.push_back({1'b0, SEL_IN2, 8'h22});
      fork
         send_tok(1, 8'h11);
         send_tok(2, 8'h22);
      join
      drain("t3_drain");

      // Fairness under continuous contention.
      for (int i = 1; i <= 4; i++) begin
         sb.push_back({1'b0, SEL_IN1, 8'(i)});
         sb.push_back({1'b0, SEL_IN2, 8'(8'h80 + i)});
      end
      fork
         for (int i = 1; i <= 4; i++) send_tok(1, 8'(i));
         for (int j = 1; j <= 4; j++) send_tok(2, 8'(8'h80 + j));
      join
      drain("t4_drain");

      // Skewed acks: select ack lags the output ack.
      sel_dly = 3;
      sb.push_back({1'b0, SEL_IN1, 8'h77});
      fork
         send_tok(1, 8'h77);
         begin
            bit seen = 0;
            for (int i = 0; i < 50 && !seen; i++) begin
               @(negedge clk);
               seen = bus.out_req;
            end
            chk("t5_out_req_rise", seen, 1);
            seen = 0;
            for (int i = 0; i < 50 && !seen; i++) begin
               @(negedge clk);
               seen = !bus.out_req;
            end
            chk("t5_out_req_fall", seen, 1);
            chk("t5_sel_req_still_high", bus.sel_req, 1);
            chk("t5_in1_ack_held_off", bus.in1_ack, 0);
            chk("t5_out_data_held", bus.out_data, 8'h77);
         end
      join
      drain("t5_drain");
      sel_dly = 0;

      // Reset while the token sits in SEND.
      out_dly = 20;
      sb.push_back({1'b0, SEL_IN1, 8'hC3});
      bus.in1_data = 8'hC3;
      bus.in1_req = 1'b1;
      @(negedge clk);
      chk("t6_out_req_before_reset", bus.out_req, 1);
      reset = 1'b1;
      bus.in1_req = 1'b0;
      @(negedge clk);
      chk("t6_out_req", bus.out_req, 0);
      chk("t6_sel_req", bus.sel_req, 0);
      chk("t6_out_data", bus.out_data, 0);
      chk("t6_sel_data", bus.sel_data, 0);
      chk("t6_in1_ack", bus.in1_ack, 0);
      chk("t6_in2_ack", bus.in2_ack, 0);
      chk("t6_state", dut.state_q, IDLE);
      reset = 1'b0;
      out_dly = 0;
      sb.push_back({1'b0, SEL_IN2, 8'h5A});
      send_tok(2, 8'h5A);
      drain("t6_drain");
      chk("t6_last_grant", dut.last_grant_q, SEL_IN2);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
